// File: rtl/controle_motores.sv
// -----------------------------------------------------------------------------
// controle_motores
//
// Drives the two traction motors and the removal arm of the robot. It takes
// level navigation commands from the sensor FSM and produces PWM enables and
// direction bits for both motors, plus the arm control.
//
// Commands are decoded with priority remover > {avancar,girar}:
//   00 PARADO, 10 FRENTE, 01 GIRO, 11 CURVA, remover -> BRACO.
//
// Ports
//   c1           in   clock
//   reset        in   synchronous active-high reset
//   avancar      in   go-forward command
//   girar        in   spin command
//   remover      in   lower the removal arm
//   mot_esq_en   out  left motor enable (PWM)
//   mot_dir_en   out  right motor enable (PWM)
//   mot_esq_fwd  out  left motor direction (1 = forward)
//   mot_dir_fwd  out  right motor direction (1 = forward)
//   braco        out  arm lowered
//   ocupado      out  commands are currently being ignored
//
// All outputs are registered. They are computed from the next-cycle state,
// PWM count and duty, so in any cycle they reflect the state held in that
// same cycle.
//
// Optional feature: define CONTROLE_SOFT_START_EN to enable soft start.
// The duty then restarts at 0 whenever a moving state is entered from
// PARADO/BRACO and climbs by one count every RAMP cycles up to DUTY. Without
// the macro the duty is the constant DUTY.
// -----------------------------------------------------------------------------
module controle_motores #(
    parameter int PWM_BITS = 4,
    parameter int DUTY     = 12,
    parameter int DWELL    = 8,
    parameter int BRAKE    = 2,
    parameter int ARM_TIME = 16,
    parameter int RAMP     = 4
) (
    input  logic c1,
    input  logic reset,
    input  logic avancar,
    input  logic girar,
    input  logic remover,
    output logic mot_esq_en,
    output logic mot_dir_en,
    output logic mot_esq_fwd,
    output logic mot_dir_fwd,
    output logic braco,
    output logic ocupado
);

    // Each counter only ever reaches its limit minus one.
    localparam int DWELL_W = (DWELL    > 1) ? $clog2(DWELL)    : 1;
    localparam int BRAKE_W = (BRAKE    > 1) ? $clog2(BRAKE)    : 1;
    localparam int ARM_W   = (ARM_TIME > 1) ? $clog2(ARM_TIME) : 1;

    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [BRAKE_W-1:0]  BRAKE_LAST = BRAKE_W'(BRAKE - 1);
    localparam logic [ARM_W-1:0]    ARM_LAST   = ARM_W'(ARM_TIME - 1);
    localparam logic [PWM_BITS-1:0] DUTY_V     = PWM_BITS'(DUTY);

`ifdef CONTROLE_SOFT_START_EN
    localparam int RAMP_W = (RAMP > 1) ? $clog2(RAMP) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP - 1);
    localparam logic [PWM_BITS-1:0] DUTY_INIT  = '0;
`else
    localparam logic [PWM_BITS-1:0] DUTY_INIT  = DUTY_V;
`endif

    typedef enum logic [2:0] {
        S_PARADO,
        S_FRENTE,
        S_GIRO,
        S_CURVA,
        S_FREIO,
        S_BRACO
    } state_t;

    state_t               state, state_next, cmd;
    logic [PWM_BITS-1:0]  pwm, pwm_next;
    logic [PWM_BITS-1:0]  duty_cur, duty_next;
    logic [DWELL_W-1:0]   dwell, dwell_next;
    logic [BRAKE_W-1:0]   brake, brake_next;
    logic [ARM_W-1:0]     arm, arm_next;
`ifdef CONTROLE_SOFT_START_EN
    logic [RAMP_W-1:0]    ramp, ramp_next;
`endif
    logic                 dwell_done, entering;
    logic                 pwm_on_n, half_on_n;
    logic                 esq_en_n, dir_en_n, esq_fwd_n, dir_fwd_n;
    logic                 braco_n, ocupado_n;

    function automatic logic is_moving(input state_t s);
        return (s == S_FRENTE) || (s == S_GIRO) || (s == S_CURVA);
    endfunction

    // The left motor reverses between GIRO and FRENTE/CURVA; only those
    // transitions need the braking pause.
    function automatic logic needs_brake(input state_t from, input state_t to);
        return ((from == S_GIRO) && ((to == S_FRENTE) || (to == S_CURVA))) ||
               (((from == S_FRENTE) || (from == S_CURVA)) && (to == S_GIRO));
    endfunction

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge c1) begin
        if (reset) begin
            state       <= S_PARADO;
            pwm         <= '0;
            duty_cur    <= DUTY_INIT;
            dwell       <= '0;
            brake       <= '0;
            arm         <= '0;
`ifdef CONTROLE_SOFT_START_EN
            ramp        <= '0;
`endif
            mot_esq_en  <= 1'b0;
            mot_dir_en  <= 1'b0;
            mot_esq_fwd <= 1'b0;
            mot_dir_fwd <= 1'b0;
            braco       <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            state       <= state_next;
            pwm         <= pwm_next;
            duty_cur    <= duty_next;
            dwell       <= dwell_next;
            brake       <= brake_next;
            arm         <= arm_next;
`ifdef CONTROLE_SOFT_START_EN
            ramp        <= ramp_next;
`endif
            mot_esq_en  <= esq_en_n;
            mot_dir_en  <= dir_en_n;
            mot_esq_fwd <= esq_fwd_n;
            mot_dir_fwd <= dir_fwd_n;
            braco       <= braco_n;
            ocupado     <= ocupado_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, counters and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // Command decode; commands are plain levels, nothing is latched, so a
        // change that reverts before it is accepted leaves no trace.
        cmd = S_PARADO;
        if (remover) begin
            cmd = S_BRACO;
        end else begin
            case ({avancar, girar})
                2'b10:   cmd = S_FRENTE;
                2'b01:   cmd = S_GIRO;
                2'b11:   cmd = S_CURVA;
                default: cmd = S_PARADO;
            endcase
        end

        dwell_done = (dwell == DWELL_LAST);

        state_next = state;
        case (state)
            S_PARADO: state_next = cmd;
            S_FRENTE, S_GIRO, S_CURVA: begin
                if ((cmd != state) && dwell_done)
                    state_next = needs_brake(state, cmd) ? S_FREIO : cmd;
            end
            // Leave with whatever is commanded on the last braking cycle.
            S_FREIO: if (brake == BRAKE_LAST) state_next = cmd;
            // The arm always returns through at least one PARADO cycle, which
            // keeps a held remover from retriggering back to back.
            S_BRACO: if (arm == ARM_LAST) state_next = S_PARADO;
            default: state_next = S_PARADO;
        endcase

        entering = (state_next != state);

        dwell_next = entering ? '0 : (dwell_done ? dwell : dwell + 1'b1);
        brake_next = (entering || (state != S_FREIO)) ? '0 : brake + 1'b1;
        arm_next   = (entering || (state != S_BRACO)) ? '0 : arm + 1'b1;
        pwm_next   = pwm + 1'b1;

`ifdef CONTROLE_SOFT_START_EN
        duty_next = duty_cur;
        ramp_next = ramp;
        if (is_moving(state_next) && ((state == S_PARADO) || (state == S_BRACO))) begin
            duty_next = '0;
            ramp_next = '0;
        end else if (is_moving(state)) begin
            // Ramp only while moving; FREIO holds the duty reached so far.
            if (ramp == RAMP_LAST) begin
                ramp_next = '0;
                if (duty_cur < DUTY_V)
                    duty_next = duty_cur + 1'b1;
            end else begin
                ramp_next = ramp + 1'b1;
            end
        end
`else
        duty_next = DUTY_V;
`endif

        pwm_on_n  = (pwm_next < duty_next);
        half_on_n = (pwm_next < (duty_next >> 1));

        // Directions hold when the motors are off.
        esq_en_n  = 1'b0;
        dir_en_n  = 1'b0;
        esq_fwd_n = mot_esq_fwd;
        dir_fwd_n = mot_dir_fwd;
        case (state_next)
            S_FRENTE: begin
                esq_en_n  = pwm_on_n;
                dir_en_n  = pwm_on_n;
                esq_fwd_n = 1'b1;
                dir_fwd_n = 1'b1;
            end
            S_GIRO: begin
                esq_en_n  = pwm_on_n;
                dir_en_n  = pwm_on_n;
                esq_fwd_n = 1'b0;
                dir_fwd_n = 1'b1;
            end
            S_CURVA: begin
                // Inner (left) wheel at half duty.
                esq_en_n  = half_on_n;
                dir_en_n  = pwm_on_n;
                esq_fwd_n = 1'b1;
                dir_fwd_n = 1'b1;
            end
            default: begin
                esq_en_n = 1'b0;
                dir_en_n = 1'b0;
            end
        endcase

        braco_n   = (state_next == S_BRACO);
        ocupado_n = (state_next == S_FREIO) || (state_next == S_BRACO) ||
                    (is_moving(state_next) && (dwell_next != DWELL_LAST));
    end

endmodule

// File: doc/controle_motores.md
CONTROLE_MOTORES -- requirements
Module: controle_motores

Interface
REQ-001 SHALL have parameter PWM_BITS, default 4, width of the PWM counter.
REQ-002 SHALL have parameter DUTY, default 12, forward duty in PWM counts (0..2^PWM_BITS-1).
REQ-003 SHALL have parameter DWELL, default 8, minimum cycles held in a moving state.
REQ-004 SHALL have parameter BRAKE, default 2, cycles with both motors off on any direction reversal.
REQ-005 SHALL have parameter ARM_TIME, default 16, cycles the removal arm stays lowered.
REQ-006 SHALL have parameter RAMP, default 4, cycles per soft-start duty step.
REQ-007 SHALL have ports: c1 in 1 clock; reset in 1 synchronous active-high reset.
REQ-008 SHALL have inputs avancar, girar, remover, each 1 bit, the navigation commands from the sensor FSM.
REQ-009 SHALL have outputs mot_esq_en, mot_dir_en, each 1 bit, motor enables (PWM).
REQ-010 SHALL have outputs mot_esq_fwd, mot_dir_fwd, each 1 bit, direction (1 = forward, 0 = reverse).
REQ-011 SHALL have outputs braco (1 bit, arm lowered) and ocupado (1 bit, commands ignored); all outputs registered.

Function
REQ-012 SHALL decode commands with priority remover > {avancar,girar}: 00 PARADO, 10 FRENTE, 01 GIRO, 11 CURVA.
REQ-013 SHALL implement states PARADO, FRENTE, GIRO, CURVA, FREIO, BRACO.
REQ-014 SHALL run a free-running PWM_BITS counter pwm; pwm_on = (pwm < duty_cur), and pwm wraps from 2^PWM_BITS-1 to 0.
REQ-015 FRENTE SHALL set both enables = pwm_on and both fwd = 1.
REQ-016 GIRO SHALL set both enables = pwm_on, mot_esq_fwd = 0, and mot_dir_fwd = 1 (spin in place).
REQ-017 CURVA SHALL set mot_dir_en = pwm_on and mot_esq_en = (pwm < duty_cur/2, truncated), with both fwd = 1.
REQ-018 PARADO, FREIO and BRACO SHALL drive both enables to 0; directions SHALL hold their previous values.
REQ-019 SHALL apply commands from PARADO on the next edge with no dwell.
REQ-020 In a moving state, a differing command SHALL be accepted only once the dwell counter reaches DWELL-1; the dwell counter SHALL clear on entry to each state.
REQ-021 A transition SHALL pass through FREIO for exactly BRAKE cycles when the motor_esq direction changes (FRENTE/CURVA <-> GIRO); otherwise it SHALL go direct.
REQ-022 After FREIO, the state SHALL be the command sampled on FREIO's last cycle (PARADO allowed).
REQ-023 remover=1 in PARADO SHALL enter BRACO immediately; from a moving state it SHALL enter BRACO after the dwell requirement is met (no FREIO).
REQ-024 BRACO SHALL hold braco=1 for ARM_TIME cycles and then return to PARADO with braco=0; remover held high SHALL NOT retrigger until one cycle in PARADO has elapsed.
REQ-025 ocupado SHALL be 1 in FREIO and BRACO, or while the dwell is unmet in a moving state; otherwise 0.
REQ-026 Command changes that revert before acceptance SHALL be ignored (level-sampled, no latching).

Reset
REQ-027 reset SHALL take priority over all inputs, sampled on the c1 rising edge.
REQ-028 On reset: state PARADO; pwm, dwell, brake, arm and ramp counters = 0; all outputs 0 (including fwd bits); duty_cur = 0 if SOFT_START_EN is defined, else DUTY.
REQ-029 Reset mid-BRACO or mid-FREIO SHALL abort immediately; braco=0 on the next cycle.

Configuration
REQ-030 With macro CONTROLE_SOFT_START_EN defined, duty_cur SHALL reset to 0 on entry to a moving state from PARADO/BRACO and increment by 1 every RAMP cycles up to DUTY.
REQ-031 duty_cur SHALL be kept across FREIO and direct moving-to-moving transitions.
REQ-032 Without CONTROLE_SOFT_START_EN, duty_cur SHALL be the constant DUTY.

Verification
REQ-033 Reset, then avancar=1 girar=0 -> FRENTE next edge; mot_*_en high 12 of every 16 cycles; both fwd = 1.
REQ-034 In FRENTE 3 cycles, switch to girar=1 avancar=0 -> stays FRENTE until 8 cycles, then 2 FREIO cycles with enables 0, then GIRO with esq_fwd=0 and dir_fwd=1.
REQ-035 avancar=girar=1 -> CURVA: mot_esq_en high 6 of 16 cycles, mot_dir_en high 12 of 16.
REQ-036 remover pulse in PARADO -> braco=1 for exactly 16 cycles, ocupado=1 throughout, then PARADO.
REQ-037 Assert reset at BRACO cycle 5 -> next cycle braco=0, ocupado=0, all enables 0.
REQ-038 With CONTROLE_SOFT_START_EN, enter FRENTE from PARADO -> duty_cur 0,1,2,... stepping every 4 cycles, saturating at 12 after 48 cycles.
